// File: rtl/svc_rv_dmem_resp.sv
// Data-memory responder for the RV core: byte-strobed word RAM with
// registered reads, plus an MMIO window holding a TX byte FIFO and a 64-bit cycle counter.
module svc_rv_dmem_resp #(
   parameter int unsigned AW         = 10,
   parameter logic [31:0] IO_BASE    = 32'h8000_0000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dmem_stall,
   input  logic        dmem_ren,
   input  logic [31:0] dmem_raddr,
   output logic [31:0] dmem_rdata,
   input  logic        dmem_we,
   input  logic [31:0] dmem_waddr,
   input  logic [31:0] dmem_wdata,
   input  logic [3:0]  dmem_wstrb,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready
);

   localparam int unsigned WORDS = 1 << AW;
   localparam int unsigned PW    = $clog2(FIFO_DEPTH);

   localparam logic [1:0] OFF_TXDATA  = 2'd0;
   localparam logic [1:0] OFF_STATUS  = 2'd1;
   localparam logic [1:0] OFF_CYC_LO  = 2'd2;
   localparam logic [1:0] OFF_CYC_HI  = 2'd3;

   logic [31:0]   r_mem [WORDS];
   logic [31:0]   r_rdata;
   logic [63:0]   r_cycle;
   logic [31:0]   r_cyc_hi;
   logic [7:0]    r_fifo [FIFO_DEPTH];
   logic [PW:0]   r_wr_ptr;
   logic [PW:0]   r_rd_ptr;
   logic          r_ovf;

   logic          w_rd_io;
   logic          w_wr_io;
   logic [AW-1:0] w_ridx;
   logic [AW-1:0] w_widx;
   logic [1:0]    w_roff;
   logic [1:0]    w_woff;
   logic          w_rd_acc;
   logic          w_ram_we;
   logic [31:0]   w_ram_rd;
   logic [31:0]   w_rd_val;
   logic [31:0]   w_status;
   logic [PW:0]   w_fill;
   logic          w_empty;
   logic          w_full;
   logic          w_pop;
   logic          w_push_req;
   logic          w_push;
   logic          w_ovf_set;
   logic          w_ovf_clr;
   logic          w_unused;

   // Address decode: bit 31 picks the MMIO window, RAM index wraps on upper bits.
   assign w_rd_io  = (dmem_raddr[31] == IO_BASE[31]);
   assign w_wr_io  = (dmem_waddr[31] == IO_BASE[31]);
   assign w_ridx   = dmem_raddr[AW+1:2];
   assign w_widx   = dmem_waddr[AW+1:2];
   assign w_roff   = dmem_raddr[3:2];
   assign w_woff   = dmem_waddr[3:2];
   assign w_rd_acc = dmem_ren & ~dmem_stall;
   assign w_ram_we = dmem_we & ~w_wr_io;

   assign w_unused = ^{dmem_raddr[30:AW+2], dmem_raddr[1:0],
                       dmem_waddr[30:AW+2], dmem_waddr[1:0]};

   // Write-first read path: strobed bytes of a same-word write bypass the array.
   always_comb begin
      w_ram_rd = r_mem[w_ridx];
      if (w_ram_we && (w_widx == w_ridx)) begin
         for (int b = 0; b < 4; b++) begin
            if (dmem_wstrb[b]) begin
               w_ram_rd[8*b +: 8] = dmem_wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (dmem_wstrb[b]) begin
               r_mem[w_widx][8*b +: 8] <= dmem_wdata[8*b +: 8];
            end
         end
      end
   end

   // FIFO status; the extra pointer bit separates full from empty.
   assign w_fill   = r_wr_ptr - r_rd_ptr;
   assign w_empty  = (w_fill == '0);
   assign w_full   = (w_fill == (PW+1)'(FIFO_DEPTH));
   assign w_status = {21'd0, w_empty, w_full, r_ovf, 8'(w_fill)};

   assign w_pop      = ~w_empty & tx_ready;
   assign w_push_req = dmem_we & w_wr_io & (w_woff == OFF_TXDATA) & dmem_wstrb[0];
   assign w_push     = w_push_req & (~w_full | w_pop);
   assign w_ovf_set  = w_push_req & w_full & ~w_pop;
   assign w_ovf_clr  = dmem_we & w_wr_io & (w_woff == OFF_STATUS) &
                       dmem_wstrb[1] & dmem_wdata[8];

   assign tx_valid = ~w_empty;
   assign tx_data  = r_fifo[r_rd_ptr[PW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_fifo[i] <= 8'd0;
         end
      end else begin
         if (w_push) begin
            r_fifo[r_wr_ptr[PW-1:0]] <= dmem_wdata[7:0];
            r_wr_ptr                 <= r_wr_ptr + (PW+1)'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
         end
      end
   end

   // Sticky overflow; a simultaneous new overflow wins over a clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (w_ovf_set) begin
         r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

   always_comb begin
      w_rd_val = w_ram_rd;
      if (w_rd_io) begin
         case (w_roff)
            OFF_TXDATA: w_rd_val = 32'd0;
            OFF_STATUS: w_rd_val = w_status;
            OFF_CYC_LO: w_rd_val = r_cycle[31:0];
            OFF_CYC_HI: w_rd_val = r_cyc_hi;
            default:    w_rd_val = 32'd0;
         endcase
      end
   end

   // Free-running counter; the high-word snapshot is taken only on an accepted LO read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cycle  <= 64'd0;
         r_cyc_hi <= 32'd0;
         r_rdata  <= 32'd0;
      end else begin
         r_cycle <= r_cycle + 64'd1;
         if (w_rd_acc) begin
            r_rdata <= w_rd_val;
            if (w_rd_io && (w_roff == OFF_CYC_LO)) begin
               r_cyc_hi <= r_cycle[63:32];
            end
         end
      end
   end

   assign dmem_rdata = r_rdata;

endmodule

// File: tb/tb_svc_rv_dmem_resp.sv
// Self-checking bench for svc_rv_dmem_resp: directed vector table, corner-case
// sequences and randomized traffic against a queue/array reference model.
module tb_svc_rv_dmem_resp;

   localparam int unsigned AW    = 10;
   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] IO    = 32'h8000_0000;

   logic        clk;
   logic        rst;
   logic        dmem_stall;
   logic        dmem_ren;
   logic [31:0] dmem_raddr;
   logic [31:0] dmem_rdata;
   logic        dmem_we;
   logic [31:0] dmem_waddr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;

   svc_rv_dmem_resp #(.AW(AW), .IO_BASE(IO), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .dmem_stall (dmem_stall),
      .dmem_ren   (dmem_ren),
      .dmem_raddr (dmem_raddr),
      .dmem_rdata (dmem_rdata),
      .dmem_we    (dmem_we),
      .dmem_waddr (dmem_waddr),
      .dmem_wdata (dmem_wdata),
      .dmem_wstrb (dmem_wstrb),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state
   logic [31:0] m_mem [1 << AW];
   bit          m_known [1 << AW];
   logic [7:0]  m_q [$];
   bit          m_ovf;
   logic [63:0] m_cycle;
   logic [31:0] m_shadow;
   logic [31:0] m_rdata;
   bit          m_rd_known;

   typedef struct {
      logic        ren;
      logic [31:0] ra;
      logic        we;
      logic [31:0] wa;
      logic [31:0] wd;
      logic [3:0]  ws;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   function automatic logic [31:0] m_status();
      logic [31:0] s;
      s = 32'd0;
      s[7:0] = 8'(m_q.size());
      s[8]   = m_ovf;
      s[9]   = (m_q.size() == DEPTH);
      s[10]  = (m_q.size() == 0);
      return s;
   endfunction

   task automatic m_reset();
      m_q.delete();
      m_ovf      = 0;
      m_cycle    = 64'd0;
      m_shadow   = 32'd0;
      m_rdata    = 32'd0;
      m_rd_known = 1;
   endtask

   // One clock: drive inputs, advance the model, then compare after the edge.
   task automatic cyc(input logic ren, input logic [31:0] ra, input logic we,
                      input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                      input logic st, input logic rdy);
      bit pop, push_req, full;
      int ri, wi;
      logic [31:0] w;
      dmem_ren = ren; dmem_raddr = ra; dmem_we = we; dmem_waddr = wa;
      dmem_wdata = wd; dmem_wstrb = ws; dmem_stall = st; tx_ready = rdy;
      ri   = int'(ra[AW+1:2]);
      wi   = int'(wa[AW+1:2]);
      pop  = (m_q.size() != 0) && rdy;
      full = (m_q.size() == DEPTH);
      if (ren && !st) begin
         if (!ra[31]) begin
            w = m_mem[ri];
            if (we && !wa[31] && wi == ri)
               for (int b = 0; b < 4; b++) if (ws[b]) w[8*b +: 8] = wd[8*b +: 8];
            m_rdata    = w;
            m_rd_known = m_known[ri];
         end else begin
            m_rd_known = 1;
            case (ra[3:2])
               2'd0: m_rdata = 32'd0;
               2'd1: m_rdata = m_status();
               2'd2: begin m_rdata = m_cycle[31:0]; m_shadow = m_cycle[63:32]; end
               default: m_rdata = m_shadow;
            endcase
         end
      end
      push_req = 0;
      if (we && !wa[31]) begin
         for (int b = 0; b < 4; b++) if (ws[b]) m_mem[wi][8*b +: 8] = wd[8*b +: 8];
         if (ws == 4'hF) m_known[wi] = 1;
      end else if (we) begin
         if (wa[3:2] == 2'd0 && ws[0]) push_req = 1;
         if (wa[3:2] == 2'd1 && ws[1] && wd[8]) m_ovf = 0;
      end
      if (push_req && full && !pop) m_ovf = 1;
      if (pop) void'(m_q.pop_front());
      if (push_req && (!full || pop)) m_q.push_back(wd[7:0]);
      m_cycle = m_cycle + 64'd1;
      @(posedge clk); #1;
      if (m_rd_known) chk("rdata", 64'(dmem_rdata), 64'(m_rdata));
      chk("tx_valid", 64'(tx_valid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) chk("tx_data", 64'(tx_data), 64'(m_q[0]));
   endtask

   task automatic idle(input logic rdy);
      cyc(0, 32'd0, 0, 32'd0, 32'd0, 4'h0, 0, rdy);
   endtask

   task automatic set_cycle(input logic [63:0] v);
      force dut.r_cycle = v;
      #1 release dut.r_cycle;
      m_cycle = v;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < (1 << AW); i++) begin m_mem[i] = 32'd0; m_known[i] = 0; end
      rst = 1; dmem_stall = 0; dmem_ren = 0; dmem_raddr = 0; dmem_we = 0;
      dmem_waddr = 0; dmem_wdata = 0; dmem_wstrb = 0; tx_ready = 0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_rdata", 64'(dmem_rdata), 64'd0);
      chk("reset_tx_valid", 64'(tx_valid), 64'd0);
      chk("reset_tx_data", 64'(tx_data), 64'd0);
      rst = 0;

      // Directed vectors: RAM strobes, write-first, address wrap, MMIO idle values
      tbl[0] = '{0, 32'h0,         1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0};
      tbl[1] = '{0, 32'h0,         1, 32'h10, 32'h0000AA00, 4'h2, 32'h0};
      tbl[2] = '{1, 32'h10,        0, 32'h0,  32'h0,        4'h0, 32'hDEADAAEF};
      tbl[3] = '{0, 32'h0,         1, 32'h20, 32'h11223344, 4'hF, 32'hDEADAAEF};
      tbl[4] = '{1, 32'h20,        1, 32'h20, 32'hFF000000, 4'h8, 32'hFF223344};
      tbl[5] = '{1, 32'h20,        0, 32'h0,  32'h0,        4'h0, 32'hFF223344};
      tbl[6] = '{1, 32'h1010,      1, 32'h24, 32'h12345678, 4'h0, 32'hDEADAAEF};
      tbl[7] = '{1, IO,            0, 32'h0,  32'h0,        4'h0, 32'h0};
      tbl[8] = '{1, IO | 32'h4,    0, 32'h0,  32'h0,        4'h0, 32'h400};
      for (int i = 0; i < 9; i++) begin
         cyc(tbl[i].ren, tbl[i].ra, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ws, 0, 0);
         chk($sformatf("vec%0d", i), 64'(dmem_rdata), 64'(tbl[i].exp));
      end

      // Overflow: five pushes into a four-entry FIFO with the sink stalled
      for (int k = 1; k <= 5; k++) cyc(0, 0, 1, IO, 32'(k), 4'h1, 0, 0);
      cyc(1, IO | 32'h4, 0, 0, 0, 4'h0, 0, 0);
      chk("status_ovf", 64'(dmem_rdata), 64'h304);
      for (int k = 1; k <= 4; k++) begin
         chk("drain_valid", 64'(tx_valid), 64'd1);
         chk("drain_data", 64'(tx_data), 64'(k));
         idle(1);
      end
      chk("drained", 64'(tx_valid), 64'd0);
      cyc(0, 0, 1, IO | 32'h4, 32'h100, 4'h2, 0, 0);
      cyc(1, IO | 32'h4, 0, 0, 0, 4'h0, 0, 0);
      chk("ovf_cleared", 64'(dmem_rdata), 64'h400);

      // Push into a full FIFO while it pops: accepted, no overflow
      for (int k = 0; k < 4; k++) cyc(0, 0, 1, IO, 32'hA0 + 32'(k), 4'h1, 0, 0);
      cyc(0, 0, 1, IO, 32'hA4, 4'h1, 0, 1);
      cyc(1, IO | 32'h4, 0, 0, 0, 4'h0, 0, 0);
      chk("full_push_pop", 64'(dmem_rdata), 64'h204);
      chk("full_push_head", 64'(tx_data), 64'hA1);
      repeat (4) idle(1);
      chk("full_drained", 64'(tx_valid), 64'd0);

      // Counter carry into the high word and the LO/HI snapshot pair
      set_cycle(64'h0000_0000_FFFF_FFFC);
      repeat (6) idle(0);
      cyc(1, IO | 32'h8, 0, 0, 0, 4'h0, 0, 0);
      chk("cyc_lo", 64'(dmem_rdata), 64'h2);
      repeat (3) idle(0);
      cyc(1, IO | 32'hC, 0, 0, 0, 4'h0, 0, 0);
      chk("cyc_hi", 64'(dmem_rdata), 64'h1);

      // Stalled reads hold rdata and do not refresh the snapshot
      cyc(1, 32'h10, 0, 0, 0, 4'h0, 1, 0);
      chk("stall_hold", 64'(dmem_rdata), 64'h1);
      set_cycle(64'h0000_0005_0000_0000);
      cyc(1, IO | 32'h8, 0, 0, 0, 4'h0, 1, 0);
      cyc(1, IO | 32'hC, 0, 0, 0, 4'h0, 0, 0);
      chk("stall_no_shadow", 64'(dmem_rdata), 64'h1);

      // Reset mid-operation with three bytes queued
      for (int k = 0; k < 3; k++) cyc(0, 0, 1, IO, 32'h50 + 32'(k), 4'h1, 0, 0);
      rst = 1;
      #1;
      chk("rst_tx_valid", 64'(tx_valid), 64'd0);
      chk("rst_rdata", 64'(dmem_rdata), 64'd0);
      chk("rst_tx_data", 64'(tx_data), 64'd0);
      #1 rst = 0;
      m_reset();
      cyc(1, IO | 32'h4, 0, 0, 0, 4'h0, 0, 0);
      chk("rst_status", 64'(dmem_rdata), 64'h400);
      cyc(1, IO | 32'hC, 0, 0, 0, 4'h0, 0, 0);
      chk("rst_shadow", 64'(dmem_rdata), 64'h0);

      // Randomized traffic against the model
      for (int i = 0; i < 16; i++) cyc(0, 0, 1, 32'(i) << 2, $urandom, 4'hF, 0, 0);
      for (int i = 0; i < 2000; i++) begin
         logic [31:0] ra, wa, wd;
         logic ren, we, st, rdy;
         if ($urandom_range(0, 3) == 0)
            ra = {1'b1, 27'($urandom), 2'($urandom), 2'b00};
         else
            ra = {1'b0, 19'($urandom), 6'd0, 4'($urandom_range(0, 15)), 2'b00};
         if ($urandom_range(0, 2) == 0)
            wa = {1'b1, 27'($urandom), 2'($urandom), 2'b00};
         else
            wa = {1'b0, 19'($urandom), 6'd0, 4'($urandom_range(0, 15)), 2'b00};
         wd  = $urandom;
         ren = 1'($urandom);
         we  = 1'($urandom);
         st  = ($urandom_range(0, 3) == 0);
         rdy = 1'($urandom);
         cyc(ren, ra, we, wa, wd, 4'($urandom), st, rdy);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
